// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding,
// memory geometry and the access-legality check.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam int MEM_WORDS_DEF = 1024;

  // 1 when the byte address is not 8-byte aligned or lies past the last word.
  function automatic logic addr_bad(input logic [63:0] addr, input int unsigned mem_words);
    logic [63:0] w_limit;
    w_limit = {32'd0, mem_words} << 3;
    return (addr[2:0] != 3'd0) || (addr >= w_limit);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter: when both request, the port that did
// not win last time gets the grant; the history advances only on accept.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_grant,
  output logic       o_winner
);

  logic r_last_grant;
  logic w_winner;

  always_comb begin
    w_winner = 1'b0;
    case (i_req)
      2'b01:   w_winner = 1'b0;
      2'b10:   w_winner = 1'b1;
      2'b11:   w_winner = ~r_last_grant;
      default: w_winner = 1'b0;
    endcase
  end

  assign o_grant  = (i_req == 2'b00) ? 2'b00 : (w_winner ? 2'b10 : 2'b01);
  assign o_winner = w_winner;

  // Reset points at port 1 so port 0 wins the first contested round.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (i_accept) begin
      r_last_grant <= w_winner;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the core LSU (port 0) and the
// loader/debug port (port 1): round-robin grant, address check, 3-state FSM.
//
// Handshakes: a request transfers on the rising edge where req_valid[p] and
// req_ready[p] are both 1; a response transfers on the edge where
// rsp_valid[p] and rsp_ready[p] are both 1. Valid, once raised, and its
// payload must be held until that edge; ready never depends on it dropping.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_we,
  input  logic [DATA_W-1:0] req_addr0,
  input  logic [DATA_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1,
  output logic [1:0]        o_dbg_state
);

  state_t r_state;
  state_t w_next;

  logic [1:0]        w_grant;
  logic              w_winner;
  logic              w_accept;
  logic              w_sel_we;
  logic [DATA_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  logic              r_owner;
  logic              r_we;
  logic              r_err;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic [CNT_W-1:0]  r_cnt0;
  logic [CNT_W-1:0]  r_cnt1;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (req_valid),
    .i_accept (w_accept),
    .o_grant  (w_grant),
    .o_winner (w_winner)
  );

  assign w_accept    = (r_state == ST_IDLE) && (req_valid != 2'b00);
  assign w_sel_we    = w_winner ? req_we[1]  : req_we[0];
  assign w_sel_addr  = w_winner ? req_addr1  : req_addr0;
  assign w_sel_wdata = w_winner ? req_wdata1 : req_wdata0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = ST_ACCESS;
      ST_ACCESS: w_next = ST_RESP;
      ST_RESP:   if (rsp_ready[r_owner]) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // An access flagged as bad keeps both strobes low so memory is never touched.
  always_comb begin
    req_ready      = 2'b00;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    case (r_state)
      ST_IDLE: req_ready = w_grant;
      ST_ACCESS: begin
        mem_address    = r_addr;
        mem_write_data = r_wdata;
        mem_read       = !r_we && !r_err;
        mem_write      = r_we && !r_err;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner     <= 1'b0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 2'b00;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_cnt0      <= '0;
      r_cnt1      <= '0;
    end else begin
      if (w_accept) begin
        r_owner <= w_winner;
        r_we    <= w_sel_we;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
        r_err   <= addr_bad(64'(w_sel_addr), MEM_WORDS);
        if (!w_winner) begin
          if (r_cnt0 != '1) r_cnt0 <= r_cnt0 + CNT_W'(1);
        end else begin
          if (r_cnt1 != '1) r_cnt1 <= r_cnt1 + CNT_W'(1);
        end
      end
      // Response data is captured once and then held until it is accepted.
      if (r_state == ST_ACCESS) begin
        r_rsp_rdata <= mem_read ? mem_read_data : '0;
        r_rsp_err   <= r_err;
        r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
      end else if ((r_state == ST_RESP) && rsp_ready[r_owner]) begin
        r_rsp_valid <= 2'b00;
      end
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign grant_cnt0  = r_cnt0;
  assign grant_cnt1  = r_cnt1;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table plus hand-built contention,
// backpressure, mid-transaction reset and counter-saturation sequences.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int DW   = 64;
  localparam int MW   = 1024;
  localparam int CW   = 10;  // narrower counters keep the saturation run short
  localparam int SB_W = 66;  // {port, err, rdata}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]    req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [DW-1:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
  logic [DW-1:0] rsp_rdata, mem_address, mem_write_data, mem_read_data;
  logic          rsp_err, mem_read, mem_write;
  logic [CW-1:0] grant_cnt0, grant_cnt1;
  logic [1:0]    o_dbg_state;

  dmem_arbiter #(.DATA_W(DW), .MEM_WORDS(MW), .CNT_W(CW)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr0      (req_addr0),
    .req_addr1      (req_addr1),
    .req_wdata0     (req_wdata0),
    .req_wdata1     (req_wdata1),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .grant_cnt0     (grant_cnt0),
    .grant_cnt1     (grant_cnt1),
    .o_dbg_state    (o_dbg_state)
  );

  // Data memory model: combinational read, write at the rising edge.
  logic [DW-1:0] mem [0:MW-1];
  initial for (int i = 0; i < MW; i++) mem[i] = '0;
  assign mem_read_data = mem[mem_address[12:3]];
  always @(posedge clk) if (mem_write) mem[mem_address[12:3]] = mem_write_data;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [SB_W-1:0] exp_q[$];

  always @(negedge clk) begin
    logic [SB_W-1:0] e;
    if (rst_n) begin
      for (int p = 0; p < 2; p++) begin
        if (rsp_valid[p] && rsp_ready[p]) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_unexpected: port %0d responded, expected none (t=%0t)", p, $time);
          end else begin
            e = exp_q.pop_front();
            check("rsp_port", p, e[65]);
            check("rsp_err", rsp_err, e[64]);
            check("rsp_rdata", rsp_rdata, e[63:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  typedef struct {
    logic        port;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        exp_err;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[14];

  // Entry and exit: one step after a rising edge, with the FSM idle or about to be.
  task automatic apply(input vec_t v);
    int         waited;
    logic [1:0] exp_onehot;
    exp_onehot = v.port ? 2'b10 : 2'b01;
    req_we[v.port] = v.we;
    if (v.port) begin
      req_addr1  = v.addr;
      req_wdata1 = v.wdata;
    end else begin
      req_addr0  = v.addr;
      req_wdata0 = v.wdata;
    end
    req_valid[v.port] = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!req_ready[v.port] && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("req_ready", req_ready, exp_onehot);
    if (!req_ready[v.port]) begin
      req_valid[v.port] = 1'b0;
      return;
    end
    check("mem_idle_req", {mem_read, mem_write}, 2'b00);
    exp_q.push_back({v.port, v.exp_err, v.exp_rdata});
    @(posedge clk); #1;
    req_valid[v.port] = 1'b0;
    @(negedge clk);
    check("mem_read", mem_read, !v.we && !v.exp_err);
    check("mem_write", mem_write, v.we && !v.exp_err);
    check("mem_address", mem_address, v.addr);
    if (v.we) check("mem_write_data", mem_write_data, v.wdata);
    check("rsp_valid_early", rsp_valid, 2'b00);
    @(negedge clk);
    check("rsp_valid", rsp_valid, exp_onehot);
    check("mem_idle_rsp", {mem_read, mem_write}, 2'b00);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, o_dbg_state, 2'd0);
    check({tag, "_req_ready"}, req_ready, 2'b00);
    check({tag, "_rsp_valid"}, rsp_valid, 2'b00);
    check({tag, "_rsp_rdata"}, rsp_rdata, 64'd0);
    check({tag, "_rsp_err"}, rsp_err, 1'b0);
    check({tag, "_mem_strobes"}, {mem_read, mem_write}, 2'b00);
    check({tag, "_mem_address"}, mem_address, 64'd0);
    check({tag, "_mem_wdata"}, mem_write_data, 64'd0);
    check({tag, "_cnt0"}, grant_cnt0, 0);
    check({tag, "_cnt1"}, grant_cnt1, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int            order[4];
    int            gcyc[4];
    int            got;
    int            budget;
    logic          gp;
    logic          wrapped;
    logic [CW-1:0] prev;

    vecs[0]  = '{1'b0, 1'b1, 64'h10,                  64'hDEAD_BEEF,             1'b0, 64'h0};
    vecs[1]  = '{1'b0, 1'b0, 64'h10,                  64'h0,                     1'b0, 64'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 1'b1, 64'h18,                  64'h1234_5678_9ABC_DEF0,   1'b0, 64'h0};
    vecs[3]  = '{1'b1, 1'b0, 64'h18,                  64'h0,                     1'b0, 64'h1234_5678_9ABC_DEF0};
    vecs[4]  = '{1'b1, 1'b0, 64'h0C,                  64'h0,                     1'b1, 64'h0};
    vecs[5]  = '{1'b1, 1'b0, 64'h2000,                64'h0,                     1'b1, 64'h0};
    vecs[6]  = '{1'b0, 1'b1, 64'h1FF8,                64'hCAFE,                  1'b0, 64'h0};
    vecs[7]  = '{1'b0, 1'b0, 64'h1FF8,                64'h0,                     1'b0, 64'hCAFE};
    vecs[8]  = '{1'b1, 1'b1, 64'h2000,                64'hBAD,                   1'b1, 64'h0};
    vecs[9]  = '{1'b0, 1'b1, 64'h14,                  64'h55,                    1'b1, 64'h0};
    vecs[10] = '{1'b0, 1'b0, 64'h10,                  64'h0,                     1'b0, 64'hDEAD_BEEF};
    vecs[11] = '{1'b1, 1'b0, 64'h1FF8,                64'h0,                     1'b0, 64'hCAFE};
    vecs[12] = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0,                     1'b1, 64'h0};
    vecs[13] = '{1'b1, 1'b0, 64'h1FF9,                64'h0,                     1'b1, 64'h0};

    rst_n = 1'b0;
    req_valid = 2'b00; req_we = 2'b00; rsp_ready = 2'b11;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Both ports saturated with stores: grants must alternate 0,1,0,1 every 3 cycles.
    for (int i = 0; i < 4; i++) begin
      order[i] = -1;
      gcyc[i]  = 0;
    end
    req_we = 2'b11;
    req_addr0 = 64'h100; req_wdata0 = 64'hA0;
    req_addr1 = 64'h200; req_wdata1 = 64'hB0;
    req_valid = 2'b11;
    got = 0;
    budget = 0;
    while (got < 4 && budget < 40) begin
      @(negedge clk);
      budget++;
      if (req_ready != 2'b00) begin
        gp = req_ready[1];
        order[got] = gp;
        gcyc[got]  = cyc;
        got++;
        exp_q.push_back({gp, 1'b0, 64'd0});
        @(posedge clk); #1;
        if (gp) begin
          req_addr1 += 8; req_wdata1 += 1;
        end else begin
          req_addr0 += 8; req_wdata0 += 1;
        end
        if (got == 4) req_valid = 2'b00;
      end
    end
    check("dual_grant_count", got, 4);
    for (int i = 0; i < 4; i++) check("dual_order", order[i], i % 2);
    for (int i = 1; i < 4; i++) check("dual_spacing", gcyc[i] - gcyc[i-1], 3);
    repeat (4) @(negedge clk);
    check("dual_drain", exp_q.size(), 0);
    check("dual_cnt0", grant_cnt0, 2);
    check("dual_cnt1", grant_cnt1, 2);
    check("dual_mem0a", mem[32], 64'hA0);
    check("dual_mem0b", mem[33], 64'hA1);
    check("dual_mem1a", mem[64], 64'hB0);
    check("dual_mem1b", mem[65], 64'hB1);
    @(posedge clk); #1;

    // Table of single-port transactions, including alignment and range boundaries.
    for (int i = 0; i < 14; i++) apply(vecs[i]);
    check("err_store_nowrite", mem[0], 64'd0);
    check("table_drain", exp_q.size(), 0);

    // Response backpressure on port 0 while port 1 waits.
    rsp_ready = 2'b10;
    req_we[0] = 1'b0; req_addr0 = 64'h10; req_valid[0] = 1'b1;
    @(negedge clk);
    check("bp_ready0", req_ready, 2'b01);
    exp_q.push_back({1'b0, 1'b0, 64'hDEAD_BEEF});
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    req_we[1] = 1'b0; req_addr1 = 64'h18; req_valid[1] = 1'b1;
    @(negedge clk);
    check("bp_ready1_access", req_ready, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 2'b01);
      check("bp_rsp_rdata", rsp_rdata, 64'hDEAD_BEEF);
      check("bp_rsp_err", rsp_err, 1'b0);
      check("bp_ready1_hold", req_ready, 2'b00);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    @(negedge clk);
    check("bp_ready1_same", req_ready, 2'b00);
    @(negedge clk);
    check("bp_ready1_after", req_ready, 2'b10);
    exp_q.push_back({1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0});
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    repeat (2) @(negedge clk);
    check("bp_rsp1_valid", rsp_valid, 2'b10);
    @(posedge clk); #1;
    check("bp_drain", exp_q.size(), 0);

    // Reset while a store sits in ACCESS; port 0 won last, yet port 0 wins after reset.
    req_we[0] = 1'b1; req_addr0 = 64'h20; req_wdata0 = 64'h1111; req_valid[0] = 1'b1;
    @(negedge clk);
    check("rst_ready0", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_pre_state", o_dbg_state, 2'd1);
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_we = 2'b00; req_addr0 = 64'h10; req_addr1 = 64'h18; req_valid = 2'b11;
    @(negedge clk);
    check("rst_first_grant", req_ready, 2'b01);
    exp_q.push_back({1'b0, 1'b0, 64'hDEAD_BEEF});
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    apply('{1'b1, 1'b0, 64'h18, 64'h0, 1'b0, 64'h1234_5678_9ABC_DEF0});
    check("rst_cnt0", grant_cnt0, 1);
    check("rst_cnt1", grant_cnt1, 1);

    // Long port-0 run drives grant_cnt0 into saturation; it must stick at all-ones.
    wrapped = 1'b0;
    prev = grant_cnt0;
    for (int i = 0; i < (1 << CW) + 4; i++) begin
      apply('{1'b0, 1'b0, 64'h10, 64'h0, 1'b0, 64'hDEAD_BEEF});
      if (grant_cnt0 < prev) wrapped = 1'b1;
      prev = grant_cnt0;
    end
    check("cnt0_no_wrap", wrapped, 1'b0);
    check("cnt0_sat", grant_cnt0, {CW{1'b1}});
    check("cnt1_hold", grant_cnt1, 1);
    repeat (3) @(negedge clk);
    check("final_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
